// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA frame scanout block: default 640x480 timing,
// the derived line/frame totals and sync windows, the frame buffer address
// width, colour bit positions, the per-pixel flag bundle that travels down
// the output pipeline, and a constant-multiply helper built from shifts/adds.
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int DEF_X_PIXELS    = 160;
   localparam int DEF_Y_PIXELS    = 120;
   localparam int DEF_SCALE_SHIFT = 2;
   localparam int DEF_H_VISIBLE   = 640;
   localparam int DEF_H_FRONT     = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BACK      = 48;
   localparam int DEF_V_VISIBLE   = 480;
   localparam int DEF_V_FRONT     = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BACK      = 33;
   localparam int DEF_CLK_DIV     = 2;

   localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   localparam int FB_ADDR_W = $clog2(DEF_X_PIXELS * DEF_Y_PIXELS);

   localparam int COLOUR_R_BIT = 2;
   localparam int COLOUR_G_BIT = 1;
   localparam int COLOUR_B_BIT = 0;

   // Decoded per-pixel flags; hsN/vsN are already in pin polarity (active low)
   typedef struct packed {
      logic vis;
      logic hsN;
      logic vsN;
      logic first;
   } scanFlags_t;

   localparam scanFlags_t FLAGS_IDLE = '{vis: 1'b0, hsN: 1'b1, vsN: 1'b1, first: 1'b0};

   // Multiply by a constant as a sum of shifted copies; with k tied to a
   // parameter this collapses to a handful of adders instead of a multiplier
   function automatic logic [31:0] shiftAddMul(input logic [31:0] value, input logic [31:0] k);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) begin
         if (k[i]) begin
            acc = acc + (value << i);
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/vga_frame_scanout_if.sv
// ---------------------------------------------------------------------------
// vga_frame_scanout_if
// Bundles the pixel-plot write side (iX, iY, iColour, iPlot) coming from the
// drawing controllers and the VGA pin side (oR/oG/oB, oHS, oVS, oBlank,
// oFrameStart) going to the DAC.
//   master : the drawing side; drives plot signals, observes VGA pins
//   slave  : the scanout block; receives plots, drives VGA pins
// ---------------------------------------------------------------------------
interface vga_frame_scanout_if;

   logic [7:0] iX;
   logic [6:0] iY;
   logic [2:0] iColour;
   logic       iPlot;

   logic       oR;
   logic       oG;
   logic       oB;
   logic       oHS;
   logic       oVS;
   logic       oBlank;
   logic       oFrameStart;

   modport master (
      output iX, iY, iColour, iPlot,
      input  oR, oG, oB, oHS, oVS, oBlank, oFrameStart
   );

   modport slave (
      input  iX, iY, iColour, iPlot,
      output oR, oG, oB, oHS, oVS, oBlank, oFrameStart
   );

endinterface

// File: rtl/frame_ram.sv
// ---------------------------------------------------------------------------
// frame_ram
// Simple dual-port frame memory: one write port, one registered read port.
// A read and write to the same address on the same edge returns the old
// contents, which matches block RAM read-first behaviour.
//   iClock   : clock
//   iWrEn    : write enable
//   iWrAddr  : write address
//   iWrData  : write data
//   iRdEn    : read enable; oRdData only updates when this is high
//   iRdAddr  : read address
//   oRdData  : read data, one clock after iRdAddr is sampled
// ---------------------------------------------------------------------------
module frame_ram #(
   parameter int DEPTH  = 19200,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 3
)(
   input  logic              iClock,
   input  logic              iWrEn,
   input  logic [ADDR_W-1:0] iWrAddr,
   input  logic [DATA_W-1:0] iWrData,
   input  logic              iRdEn,
   input  logic [ADDR_W-1:0] iRdAddr,
   output logic [DATA_W-1:0] oRdData
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write and read share one process so the read samples the array before
   // the write lands; there is deliberately no reset so it maps onto block RAM
   always_ff @(posedge iClock) begin
      if (iWrEn) begin
         r_mem[iWrAddr] <= iWrData;
      end
      if (iRdEn) begin
         oRdData <= r_mem[iRdAddr];
      end
   end

endmodule

// File: rtl/vga_frame_scanout.sv
// ---------------------------------------------------------------------------
// vga_frame_scanout
// Accepts plotted pixels into a low-resolution frame buffer and scans it out
// as VGA video, each logical pixel blown up to a 2^SCALE_SHIFT square.
//   iClock : system clock
//   iReset : asynchronous active-high reset
//   vga    : slave side of vga_frame_scanout_if
//            plot inputs iX/iY/iColour/iPlot (one write per clock while iPlot)
//            VGA outputs oR/oG/oB, oHS/oVS (active low), oBlank, oFrameStart
// Counter values reach the pins two pixel ticks later; colour, blank and
// sync all travel through the same two stages so they stay aligned.
// ---------------------------------------------------------------------------
module vga_frame_scanout
   import vga_pkg::*;
#(
   parameter int X_PIXELS    = DEF_X_PIXELS,
   parameter int Y_PIXELS    = DEF_Y_PIXELS,
   parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
   parameter int H_VISIBLE   = DEF_H_VISIBLE,
   parameter int H_FRONT     = DEF_H_FRONT,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BACK      = DEF_H_BACK,
   parameter int V_VISIBLE   = DEF_V_VISIBLE,
   parameter int V_FRONT     = DEF_V_FRONT,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BACK      = DEF_V_BACK,
   parameter int CLK_DIV     = DEF_CLK_DIV
)(
   input logic                iClock,
   input logic                iReset,
   vga_frame_scanout_if.slave vga
);

   localparam int H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HC_W   = $clog2(H_TOT);
   localparam int VC_W   = $clog2(V_TOT);
   localparam int DEPTH  = X_PIXELS * Y_PIXELS;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [HC_W-1:0]  HC_LAST    = HC_W'(H_TOT - 1);
   localparam logic [VC_W-1:0]  VC_LAST    = VC_W'(V_TOT - 1);
   localparam logic [HC_W-1:0]  H_VIS_C    = HC_W'(H_VISIBLE);
   localparam logic [VC_W-1:0]  V_VIS_C    = VC_W'(V_VISIBLE);
   localparam logic [HC_W-1:0]  HS_START_C = HC_W'(H_VISIBLE + H_FRONT);
   localparam logic [HC_W-1:0]  HS_END_C   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [VC_W-1:0]  VS_START_C = VC_W'(V_VISIBLE + V_FRONT);
   localparam logic [VC_W-1:0]  VS_END_C   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [31:0]      X_LIM      = 32'(X_PIXELS);
   localparam logic [31:0]      Y_LIM      = 32'(Y_PIXELS);

   logic [DIV_W-1:0]  r_div;
   logic              w_tick;
   logic [HC_W-1:0]   r_hc;
   logic [VC_W-1:0]   r_vc;
   scanFlags_t        w_flags;
   scanFlags_t        r_s1Flags;
   logic [ADDR_W-1:0] w_rdAddr;
   logic [ADDR_W-1:0] w_wrAddr;
   logic              w_wrEn;
   logic [2:0]        w_rdData;
   logic [2:0]        r_rgb;
   logic              r_hsN;
   logic              r_vsN;
   logic              r_blank;
   logic              r_frameStart;

   // Pixel tick generator; with CLK_DIV=1 the counter sits at 0 and the
   // compare against DIV_LAST=0 keeps the tick permanently high
   assign w_tick = (r_div == DIV_LAST);

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Raster position; the line counter only moves when the pixel counter wraps
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (w_tick) begin
         if (r_hc == HC_LAST) begin
            r_hc <= '0;
            if (r_vc == VC_LAST) begin
               r_vc <= '0;
            end else begin
               r_vc <= r_vc + VC_W'(1);
            end
         end else begin
            r_hc <= r_hc + HC_W'(1);
         end
      end
   end

   // Decode the current raster position into the flags that must reach the
   // pins in step with the pixel colour
   always_comb begin
      w_flags       = FLAGS_IDLE;
      w_flags.vis   = (r_hc < H_VIS_C) && (r_vc < V_VIS_C);
      w_flags.hsN   = !((r_hc >= HS_START_C) && (r_hc < HS_END_C));
      w_flags.vsN   = !((r_vc >= VS_START_C) && (r_vc < VS_END_C));
      w_flags.first = (r_hc == '0) && (r_vc == '0);
   end

   // Frame buffer addressing. Off-screen read addresses are garbage, which is
   // harmless because vis masks the colour. Writes outside the logical frame
   // are dropped before address truncation could alias them onto real pixels.
   assign w_rdAddr = ADDR_W'(shiftAddMul(32'(r_vc >> SCALE_SHIFT), X_LIM)
                             + 32'(r_hc >> SCALE_SHIFT));
   assign w_wrEn   = vga.iPlot && ({24'd0, vga.iX} < X_LIM) && ({25'd0, vga.iY} < Y_LIM);
   assign w_wrAddr = ADDR_W'(shiftAddMul({25'd0, vga.iY}, X_LIM) + {24'd0, vga.iX});

   // Stage 1 read: the RAM's own read register holds the pixel data, sampled
   // only on ticks so it stays put until stage 2 consumes it
   frame_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (3)
   ) uFrameRam (
      .iClock  (iClock),
      .iWrEn   (w_wrEn),
      .iWrAddr (w_wrAddr),
      .iWrData (vga.iColour),
      .iRdEn   (w_tick),
      .iRdAddr (w_rdAddr),
      .oRdData (w_rdData)
   );

   // Stage 1 flags, captured on the same tick as the RAM read
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_s1Flags <= FLAGS_IDLE;
      end else if (w_tick) begin
         r_s1Flags <= w_flags;
      end
   end

   // Stage 2 drives the pins on the following tick and holds them between
   // ticks. The frame-start strobe is cleared on every non-tick clock so it
   // stays exactly one system clock wide whatever the divider setting.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_rgb        <= 3'b000;
         r_hsN        <= 1'b1;
         r_vsN        <= 1'b1;
         r_blank      <= 1'b1;
         r_frameStart <= 1'b0;
      end else begin
         r_frameStart <= w_tick && r_s1Flags.first;
         if (w_tick) begin
            r_rgb   <= r_s1Flags.vis ? w_rdData : 3'b000;
            r_hsN   <= r_s1Flags.hsN;
            r_vsN   <= r_s1Flags.vsN;
            r_blank <= !r_s1Flags.vis;
         end
      end
   end

   assign vga.oR          = r_rgb[COLOUR_R_BIT];
   assign vga.oG          = r_rgb[COLOUR_G_BIT];
   assign vga.oB          = r_rgb[COLOUR_B_BIT];
   assign vga.oHS         = r_hsN;
   assign vga.oVS         = r_vsN;
   assign vga.oBlank      = r_blank;
   assign vga.oFrameStart = r_frameStart;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_scanout
// Drives a tiny 4x2 configuration (14x7 raster, CLK_DIV=1) with directed
// plots and compares every output cycle against a reference of the raster,
// plus a default-size instance with CLK_DIV=2 for real VGA line timing.
// ---------------------------------------------------------------------------
module tb_vga_frame_scanout;

   logic clock = 1'b0;
   logic reset;

   vga_frame_scanout_if ifSmall ();
   vga_frame_scanout_if ifBig ();

   vga_frame_scanout #(
      .X_PIXELS (4), .Y_PIXELS (2), .SCALE_SHIFT (1),
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .CLK_DIV (1)
   ) uSmall (
      .iClock (clock),
      .iReset (reset),
      .vga    (ifSmall)
   );

   vga_frame_scanout #(
      .CLK_DIV (2)
   ) uBig (
      .iClock (clock),
      .iReset (reset),
      .vga    (ifBig)
   );

   // Free-running clock
   always #5 clock = ~clock;

   int         checks;
   int         passes;
   int         k;
   int         wEdge;
   int         lastFsK;
   int         hsLowCnt;
   int         vsLowCnt;
   int         fsCnt;
   bit         cycleCheckOn;
   logic [2:0] memNow  [8];
   logic [2:0] memPrev [8];

   // Compare one observed value against its expected value and tally it
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Outputs packed as {R,G,B,HS,VS,Blank,FrameStart}
   function automatic logic [6:0] smallOutputs();
      return {ifSmall.oR, ifSmall.oG, ifSmall.oB, ifSmall.oHS, ifSmall.oVS,
              ifSmall.oBlank, ifSmall.oFrameStart};
   endfunction

   function automatic logic [6:0] bigOutputs();
      return {ifBig.oR, ifBig.oG, ifBig.oB, ifBig.oHS, ifBig.oVS,
              ifBig.oBlank, ifBig.oFrameStart};
   endfunction

   // Reference for the small config after edge kk following reset release:
   // the pins show raster position n = kk-2, whose data was read at edge kk-1
   function automatic logic [6:0] expectSmall(int kk);
      int         n;
      int         hc;
      int         vc;
      logic       vis;
      logic       hs;
      logic       vs;
      logic       fs;
      logic [2:0] col;
      if (kk < 2) begin
         return 7'b000_1_1_1_0;
      end
      n   = kk - 2;
      hc  = n % 14;
      vc  = (n / 14) % 7;
      vis = (hc < 8) && (vc < 4);
      hs  = !((hc >= 10) && (hc < 12));
      vs  = (vc != 5);
      fs  = (hc == 0) && (vc == 0);
      col = 3'b000;
      if (vis) begin
         col = ((kk - 1) > wEdge) ? memNow[(vc / 2) * 4 + hc / 2]
                                  : memPrev[(vc / 2) * 4 + hc / 2];
      end
      return {col, hs, vs, !vis, fs};
   endfunction

   // Advance one clock, sample 1 time unit after the edge, check the small DUT
   task automatic runCycle();
      @(posedge clock);
      #1;
      k++;
      if (cycleCheckOn) begin
         checkOutput($sformatf("small outputs k=%0d", k), 32'(smallOutputs()), 32'(expectSmall(k)));
         if (k >= 2 && k <= 99) begin
            hsLowCnt += (ifSmall.oHS == 1'b0) ? 1 : 0;
            vsLowCnt += (ifSmall.oVS == 1'b0) ? 1 : 0;
            fsCnt    += (ifSmall.oFrameStart == 1'b1) ? 1 : 0;
         end
         if (ifSmall.oFrameStart == 1'b1) begin
            if (lastFsK >= 0) begin
               checkOutput("frame start period", 32'(k - lastFsK), 32'd98);
            end
            lastFsK = k;
         end
      end
   endtask

   task automatic runTo(input int target);
      while (k < target) begin
         runCycle();
      end
   endtask

   // One-clock plot into the small DUT; in-range writes also update the model
   task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [2:0] colour);
      ifSmall.iX      = x;
      ifSmall.iY      = y;
      ifSmall.iColour = colour;
      ifSmall.iPlot   = 1'b1;
      if (x < 8'd4 && y < 7'd2) begin
         memPrev = memNow;
         memNow[int'(y) * 4 + int'(x)] = colour;
         wEdge = k + 1;
      end
      runCycle();
      ifSmall.iPlot = 1'b0;
   endtask

   task automatic releaseReset();
      @(posedge clock);
      #1;
      reset    = 1'b0;
      k        = 0;
      lastFsK  = -1;
      hsLowCnt = 0;
      vsLowCnt = 0;
      fsCnt    = 0;
      memPrev  = memNow;
      wEdge    = 0;
   endtask

   // Wait (bounded) for the big DUT's HSYNC to reach a level; returns cycles used
   task automatic waitBigHs(input logic level, input int budget, output bit ok, output int used);
      ok   = 1'b0;
      used = 0;
      for (int i = 0; i < budget; i++) begin
         runCycle();
         used++;
         if (ifBig.oHS === level) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Directed test sequence
   initial begin
      bit ok;
      int used;
      int lowLen;
      int period;
      checks          = 0;
      passes          = 0;
      k               = 0;
      wEdge           = 0;
      lastFsK         = -1;
      hsLowCnt        = 0;
      vsLowCnt        = 0;
      fsCnt           = 0;
      cycleCheckOn    = 1'b0;
      reset           = 1'b1;
      ifSmall.iX      = '0;
      ifSmall.iY      = '0;
      ifSmall.iColour = '0;
      ifSmall.iPlot   = 1'b0;
      ifBig.iX        = '0;
      ifBig.iY        = '0;
      ifBig.iColour   = '0;
      ifBig.iPlot     = 1'b0;
      for (int a = 0; a < 8; a++) begin
         memNow[a]  = 3'b000;
         memPrev[a] = 3'b000;
      end

      repeat (3) runCycle();
      checkOutput("small reset outputs", 32'(smallOutputs()), 32'(7'b000_1_1_1_0));
      checkOutput("big reset outputs", 32'(bigOutputs()), 32'(7'b000_1_1_1_0));

      // Memory is not cleared by reset, so clear it through the plot port
      for (int a = 0; a < 8; a++) begin
         applyStimulus(8'(a % 4), 7'(a / 4), 3'b000);
      end
      applyStimulus(8'd1, 7'd0, 3'b101);
      applyStimulus(8'd3, 7'd1, 3'b010);

      cycleCheckOn = 1'b1;
      releaseReset();

      runTo(2);
      checkOutput("frame start at (0,0)", 32'(ifSmall.oFrameStart), 32'd1);
      runTo(4);
      checkOutput("pixel (2,0) rgb", 32'(smallOutputs() >> 4), 32'h5);
      runTo(6);
      checkOutput("pixel (4,0) rgb", 32'(smallOutputs() >> 4), 32'h0);
      runTo(19);
      checkOutput("pixel (3,1) rgb", 32'(smallOutputs() >> 4), 32'h5);
      runTo(36);
      checkOutput("pixel (6,2) rgb", 32'(smallOutputs() >> 4), 32'h2);
      runTo(51);
      checkOutput("pixel (7,3) rgb", 32'(smallOutputs() >> 4), 32'h2);
      runTo(99);
      checkOutput("hs low clocks per frame", 32'(hsLowCnt), 32'd14);
      checkOutput("vs low clocks per frame", 32'(vsLowCnt), 32'd14);
      checkOutput("frame starts per frame", 32'(fsCnt), 32'd1);
      runTo(199);

      // Out-of-range plots that would alias onto addresses 4 and 0
      applyStimulus(8'd4, 7'd0, 3'b111);
      applyStimulus(8'd0, 7'd2, 3'b111);
      runTo(296);
      checkOutput("pixel (0,0) after dropped plot", 32'(smallOutputs() >> 4), 32'h0);

      // Write address 0 on the edge that reads it for screen pixel (1,1)
      runTo(309);
      applyStimulus(8'd0, 7'd0, 3'b110);
      runTo(311);
      checkOutput("pixel (1,1) old value", 32'(smallOutputs() >> 4), 32'h0);
      runTo(324);
      checkOutput("pixel (0,2) after dropped plot", 32'(smallOutputs() >> 4), 32'h0);
      runTo(394);
      checkOutput("pixel (0,0) new value", 32'(smallOutputs() >> 4), 32'h6);
      runTo(395);
      checkOutput("pixel (1,0) new value", 32'(smallOutputs() >> 4), 32'h6);

      // Mid-line reset while HSYNC is low (screen hc=11)
      runTo(405);
      checkOutput("hs low before reset", 32'(ifSmall.oHS), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("small async reset outputs", 32'(smallOutputs()), 32'(7'b000_1_1_1_0));
      checkOutput("big async reset outputs", 32'(bigOutputs()), 32'(7'b000_1_1_1_0));
      cycleCheckOn = 1'b0;
      repeat (2) runCycle();
      cycleCheckOn = 1'b1;
      releaseReset();
      runTo(2);
      checkOutput("frame start 2 clocks after release", 32'(ifSmall.oFrameStart), 32'd1);
      runTo(3);
      checkOutput("big frame start k=3", 32'(ifBig.oFrameStart), 32'd0);
      checkOutput("big blank k=3", 32'(ifBig.oBlank), 32'd1);
      runTo(4);
      checkOutput("big frame start k=4", 32'(ifBig.oFrameStart), 32'd1);
      checkOutput("big blank k=4", 32'(ifBig.oBlank), 32'd0);
      runTo(5);
      checkOutput("big frame start k=5", 32'(ifBig.oFrameStart), 32'd0);
      runTo(99);
      checkOutput("hs low clocks after reset", 32'(hsLowCnt), 32'd14);
      checkOutput("vs low clocks after reset", 32'(vsLowCnt), 32'd14);
      checkOutput("frame starts after reset", 32'(fsCnt), 32'd1);
      runTo(110);

      // Full-size timing with the 2:1 divider
      waitBigHs(1'b0, 4000, ok, used);
      checkOutput("big hs first fall seen", 32'(ok), 32'd1);
      checkOutput("big vs idle early in frame", 32'(ifBig.oVS), 32'd1);
      waitBigHs(1'b1, 400, ok, lowLen);
      checkOutput("big hs rise seen", 32'(ok), 32'd1);
      checkOutput("big hs low clocks", 32'(lowLen), 32'd192);
      waitBigHs(1'b0, 2000, ok, used);
      period = lowLen + used;
      checkOutput("big hs second fall seen", 32'(ok), 32'd1);
      checkOutput("big hs period clocks", 32'(period), 32'd1600);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vga_frame_scanout.md
Name: vga_frame_scanout

Overview:
- Receiving end of the pixel-plot interface driven by the character and animation controllers (X, Y, colour, plot strobe).
- Stores plotted pixels in an internal 160x120x3 frame memory.
- Continuously reads that memory in raster order and drives VGA colour, sync and blank signals.
- Sits between the drawing FSMs and the board's VGA DAC/connector.

Parameters:
- X_PIXELS, 160, logical framebuffer width
- Y_PIXELS, 120, logical framebuffer height
- SCALE_SHIFT, 2, each logical pixel is shown as a 2^SCALE_SHIFT square of screen pixels
- H_VISIBLE, 640, visible screen pixels per line
- H_FRONT, 16, horizontal front porch, in pixel ticks
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- CLK_DIV, 2, system clocks per pixel tick (50 MHz clock gives a 25 MHz pixel rate)

Ports:
- iClock  in  1  system clock
- iReset  in  1  asynchronous, active-high reset
- iX  in  8  plot X coordinate
- iY  in  7  plot Y coordinate
- iColour  in  3  plot colour
- iPlot  in  1  write strobe; one pixel is written per clock while high
- oR  out  1  red output; colour bits are R=iColour[2], G=iColour[1], B=iColour[0]
- oG  out  1  green output
- oB  out  1  blue output
- oHS  out  1  horizontal sync, active low
- oVS  out  1  vertical sync, active low
- oBlank  out  1  high outside the visible area
- oFrameStart  out  1  one-clock pulse at the pixel tick of screen position (0,0)

Behaviour:
- Reset (async assert, released on a clock edge): hc=0, vc=0, divider=0, oHS=1, oVS=1, oBlank=1, oR/oG/oB=0, oFrameStart=0.
- Frame memory is not cleared by reset.
- Write port: on a posedge with iPlot=1, iX<X_PIXELS and iY<Y_PIXELS, write mem[iY*X_PIXELS+iX]=iColour.
- Out-of-range writes are silently dropped.
- Writes are accepted every cycle; there is no back-pressure.
- Pixel tick: a divider counts 0..CLK_DIV-1; tick=1 when divider==CLK_DIV-1. With CLK_DIV=1, tick is always 1.
- Raster counters advance only on a tick:
  - hc runs 0..H_TOTAL-1, where H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK.
  - When hc wraps, vc increments; vc runs 0..V_TOTAL-1 and then wraps to 0.
- Read address = (vc>>SCALE_SHIFT)*X_PIXELS + (hc>>SCALE_SHIFT). It is only meaningful when hc<H_VISIBLE and vc<V_VISIBLE.
- Memory read is synchronous with a 1-clock latency.
- Stage 1, on a tick: register the address, plus the decoded vis, hs and vs flags.
  - vis = hc<H_VISIBLE && vc<V_VISIBLE
  - hs_n = !(hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC))
  - vs_n is the same form using vc and the V_ parameters
- Stage 2, on the next tick: drive outputs from the registered values.
  - oR/oG/oB = vis ? mem data : 0
  - oBlank = !vis
  - oHS = hs_n, oVS = vs_n
- Total pipeline latency is 2 ticks from counter value to pins. Sync, blank and colour must stay mutually aligned.
- oFrameStart: one-clock pulse on the same clock edge at which the outputs for screen pixel (0,0) appear.
- Simultaneous write and read of the same address: read returns the old data (read-before-write). The new value appears on the next frame.
- Outputs hold between ticks.
- Reset asserted mid-frame returns everything to the reset state immediately. After release, scanning restarts at (0,0).
- Width rules:
  - hc and vc are $clog2(total) bits wide.
  - The address is $clog2(X_PIXELS*Y_PIXELS) bits wide, 15 by default.
  - The multiply by the constant X_PIXELS is implemented with shift-add, not an inferred multiplier.

Decomposition:
- Shared package vga_pkg holds:
  - the timing localparams H_TOTAL, V_TOTAL and the sync start/end positions
  - FB_ADDR_W
  - the colour bit-index constants
- Sub-module frame_ram: simple dual-port RAM (write port, registered read port, read-before-write), inferable as on-chip block RAM.
- Raster counters and the output pipeline stay in the top module.

Test Plan:
All tests except test 6 use X_PIXELS=4, Y_PIXELS=2, SCALE_SHIFT=1, H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), CLK_DIV=1.
1. Reset, then run 14*7 clocks -> oHS low exactly 2 clocks per line, at output hc 10-11 delayed by 2; oVS low for exactly one line per frame; oFrameStart pulses every 98 clocks.
2. Plot (1,0)=3'b101 and (3,1)=3'b010, then scan a frame -> screen pixels x=2-3, y=0-1 show R=1,G=0,B=1; screen pixels x=6-7, y=2-3 show G only; all other visible pixels are 0.
3. Plot (4,0) and (0,2) (out of range) -> memory unchanged; the next frame is identical to the previous one.
4. Write address 0 on the same clock it is read -> the current frame shows the old value; the next frame shows the new value.
5. Assert iReset mid-line -> all outputs are immediately at reset values; after release, the first oFrameStart occurs 2 clocks after release and sync timing matches test 1.
6. Default parameters with CLK_DIV=2 -> HS period 1600 clocks, VS period 840000 clocks, sync low 192 clocks per line.
